// File: rtl/vx_commit_arb_pkg.sv
// Shared types and constants for the commit arbiter: packet layout and
// execute-unit indices.
package vx_commit_arb_pkg;

  localparam int NUM_EX      = 4;
  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int NR_BITS     = 6;
  localparam int WIS_BITS    = 2;
  localparam int UUID_WIDTH  = 44;
  localparam int CTR_BITS    = 64;

  localparam int EX_ALU = 0;
  localparam int EX_LSU = 1;
  localparam int EX_FPU = 2;
  localparam int EX_SFU = 3;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]       uuid;
    logic [WIS_BITS-1:0]         wis;
    logic [NUM_THREADS-1:0]      tmask;
    logic [NR_BITS-1:0]          rd;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic                        eop;
  } commit_pkt_t;

  typedef commit_pkt_t wb_pkt_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at a rotating pointer that
// moves past the winner whenever a grant is issued.
module vx_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    idx      = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = PW'((int'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr <= '0;
    else        ptr <= ptr_next;
  end

endmodule

// File: rtl/vx_commit_arb.sv
// Writeback transmitter for one issue slot: arbitrates writing commits onto a
// registered writeback port, retires non-writing commits at once, counts retires.
module vx_commit_arb #(
  parameter int NUM_EX      = vx_commit_arb_pkg::NUM_EX,
  parameter int NUM_THREADS = vx_commit_arb_pkg::NUM_THREADS,
  parameter int XLEN        = vx_commit_arb_pkg::XLEN,
  parameter int NR_BITS     = vx_commit_arb_pkg::NR_BITS,
  parameter int WIS_BITS    = vx_commit_arb_pkg::WIS_BITS,
  parameter int UUID_WIDTH  = vx_commit_arb_pkg::UUID_WIDTH,
  parameter int CTR_BITS    = vx_commit_arb_pkg::CTR_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_EX-1:0]                  commit_valid,
  output logic [NUM_EX-1:0]                  commit_ready,
  input  logic [NUM_EX-1:0]                  commit_wb,
  input  logic [NUM_EX-1:0]                  commit_eop,
  input  logic [NUM_EX*UUID_WIDTH-1:0]       commit_uuid,
  input  logic [NUM_EX*WIS_BITS-1:0]         commit_wis,
  input  logic [NUM_EX*NUM_THREADS-1:0]      commit_tmask,
  input  logic [NUM_EX*NR_BITS-1:0]          commit_rd,
  input  logic [NUM_EX*NUM_THREADS*XLEN-1:0] commit_data,
  output logic                               wb_valid,
  output logic [UUID_WIDTH-1:0]              wb_uuid,
  output logic [WIS_BITS-1:0]                wb_wis,
  output logic [NUM_THREADS-1:0]             wb_tmask,
  output logic [NR_BITS-1:0]                 wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]        wb_data,
  output logic                               wb_eop,
  output logic [CTR_BITS-1:0]                retired_count
);

  import vx_commit_arb_pkg::*;

  localparam int DW = NUM_THREADS * XLEN;
  localparam int IW = $clog2(NUM_EX + 1);

  logic [NUM_EX-1:0]   req;
  logic [NUM_EX-1:0]   grant;
  logic [NUM_EX-1:0]   no_wb;
  logic [NUM_EX-1:0]   fire_eop;
  logic [IW-1:0]       retire_inc;
  commit_pkt_t         sel_pkt;
  wb_pkt_t             wb_q;
  logic                wb_valid_q;
  logic [CTR_BITS-1:0] retired_q;

  // Everything is gated by reset so nothing is accepted while it is held.
  assign req          = commit_valid & commit_wb & {NUM_EX{reset}};
  assign no_wb        = commit_valid & ~commit_wb;
  assign commit_ready = reset ? (grant | no_wb) : '0;
  assign fire_eop     = commit_valid & commit_ready & commit_eop;

  vx_rr_arbiter #(.N(NUM_EX)) arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  always_comb begin
    sel_pkt    = '0;
    retire_inc = '0;
    for (int i = 0; i < NUM_EX; i++) begin
      if (grant[i]) begin
        sel_pkt.uuid  = commit_uuid[i*UUID_WIDTH +: UUID_WIDTH];
        sel_pkt.wis   = commit_wis[i*WIS_BITS +: WIS_BITS];
        sel_pkt.tmask = commit_tmask[i*NUM_THREADS +: NUM_THREADS];
        sel_pkt.rd    = commit_rd[i*NR_BITS +: NR_BITS];
        sel_pkt.data  = commit_data[i*DW +: DW];
        sel_pkt.eop   = commit_eop[i];
      end
      retire_inc = retire_inc + IW'(fire_eop[i]);
    end
  end

  // Fields only reload on a grant; they are stale while wb_valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
      retired_q  <= '0;
    end else begin
      wb_valid_q <= |grant;
      if (|grant) wb_q <= sel_pkt;
      retired_q  <= retired_q + CTR_BITS'(retire_inc);
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_uuid       = wb_q.uuid;
  assign wb_wis        = wb_q.wis;
  assign wb_tmask      = wb_q.tmask;
  assign wb_rd         = wb_q.rd;
  assign wb_data       = wb_q.data;
  assign wb_eop        = wb_q.eop;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_vx_commit_arb.sv
// Self-checking bench for vx_commit_arb: directed scenarios plus random
// traffic compared against a behavioural round-robin/retire model.
module tb_vx_commit_arb;

  localparam int NE = 4;
  localparam int NT = 4;
  localparam int XL = 32;
  localparam int NR = 6;
  localparam int WB = 2;
  localparam int UW = 44;
  localparam int CW = 64;
  localparam int DW = NT * XL;

  logic              clk = 1'b0;
  logic              reset;
  logic [NE-1:0]     commit_valid;
  logic [NE-1:0]     commit_ready;
  logic [NE-1:0]     commit_wb;
  logic [NE-1:0]     commit_eop;
  logic [NE*UW-1:0]  commit_uuid;
  logic [NE*WB-1:0]  commit_wis;
  logic [NE*NT-1:0]  commit_tmask;
  logic [NE*NR-1:0]  commit_rd;
  logic [NE*DW-1:0]  commit_data;
  logic              wb_valid;
  logic [UW-1:0]     wb_uuid;
  logic [WB-1:0]     wb_wis;
  logic [NT-1:0]     wb_tmask;
  logic [NR-1:0]     wb_rd;
  logic [DW-1:0]     wb_data;
  logic              wb_eop;
  logic [CW-1:0]     retired_count;

  always #5 clk = ~clk;

  vx_commit_arb dut (
    .clk           (clk),
    .reset         (reset),
    .commit_valid  (commit_valid),
    .commit_ready  (commit_ready),
    .commit_wb     (commit_wb),
    .commit_eop    (commit_eop),
    .commit_uuid   (commit_uuid),
    .commit_wis    (commit_wis),
    .commit_tmask  (commit_tmask),
    .commit_rd     (commit_rd),
    .commit_data   (commit_data),
    .wb_valid      (wb_valid),
    .wb_uuid       (wb_uuid),
    .wb_wis        (wb_wis),
    .wb_tmask      (wb_tmask),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_eop        (wb_eop),
    .retired_count (retired_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: rotating start index, retire total, expected beat.
  int            m_ptr;
  logic [CW-1:0] m_count;
  bit            m_beat;
  logic [UW-1:0] m_uuid;
  logic [WB-1:0] m_wis;
  logic [NT-1:0] m_tmask;
  logic [NR-1:0] m_rd;
  logic [DW-1:0] m_data;
  logic          m_eop;
  logic [NE-1:0] m_ready;
  int            m_grant;
  int            m_inc;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelEval();
    m_ready = '0;
    m_grant = -1;
    m_inc   = 0;
    for (int k = 0; k < NE; k++) begin
      int i;
      i = (m_ptr + k) % NE;
      if (m_grant < 0 && commit_valid[i] && commit_wb[i]) m_grant = i;
    end
    for (int i = 0; i < NE; i++)
      if (commit_valid[i] && !commit_wb[i]) m_ready[i] = 1'b1;
    if (m_grant >= 0) m_ready[m_grant] = 1'b1;
    for (int i = 0; i < NE; i++)
      if (m_ready[i] && commit_eop[i]) m_inc++;
  endtask

  task automatic applyStimulus(input logic [NE-1:0] v, input logic [NE-1:0] w, input logic [NE-1:0] e);
    commit_valid = v;
    commit_wb    = w;
    commit_eop   = e;
    for (int i = 0; i < NE; i++) commit_uuid[i*UW +: UW] = {12'($urandom), $urandom};
    commit_wis   = 8'($urandom);
    commit_tmask = 16'($urandom);
    commit_rd    = 24'($urandom);
    for (int j = 0; j < NE*NT; j++) commit_data[j*XL +: XL] = $urandom;
  endtask

  task automatic checkOutput();
    #1;
    modelEval();
    checkVal("commit_ready", 128'(commit_ready), 128'(m_ready));
    @(posedge clk);
    if (m_grant >= 0) begin
      m_beat  = 1'b1;
      m_uuid  = commit_uuid[m_grant*UW +: UW];
      m_wis   = commit_wis[m_grant*WB +: WB];
      m_tmask = commit_tmask[m_grant*NT +: NT];
      m_rd    = commit_rd[m_grant*NR +: NR];
      m_data  = commit_data[m_grant*DW +: DW];
      m_eop   = commit_eop[m_grant];
      m_ptr   = (m_grant + 1) % NE;
    end else begin
      m_beat = 1'b0;
    end
    m_count = m_count + CW'(m_inc);
    #1;
    checkVal("wb_valid", 128'(wb_valid), 128'(m_beat));
    if (m_beat) begin
      checkVal("wb_uuid",  128'(wb_uuid),  128'(m_uuid));
      checkVal("wb_wis",   128'(wb_wis),   128'(m_wis));
      checkVal("wb_tmask", 128'(wb_tmask), 128'(m_tmask));
      checkVal("wb_rd",    128'(wb_rd),    128'(m_rd));
      checkVal("wb_data",  128'(wb_data),  128'(m_data));
      checkVal("wb_eop",   128'(wb_eop),   128'(m_eop));
    end
    checkVal("retired_count", 128'(retired_count), 128'(m_count));
  endtask

  initial begin
    int lsu_beats;
    int guard;
    m_ptr   = 0;
    m_count = '0;
    m_beat  = 1'b0;

    // Reset held with every unit requesting.
    reset = 1'b0;
    applyStimulus(4'hF, 4'hF, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_ready",    128'(commit_ready),  128'(0));
    checkVal("reset_wb_valid", 128'(wb_valid),      128'(0));
    checkVal("reset_count",    128'(retired_count), 128'(0));
    checkVal("reset_wb_data",  128'(wb_data),       128'(0));
    checkVal("reset_wb_rd",    128'(wb_rd),         128'(0));
    reset = 1'b1;
    #1 checkVal("first_grant", 128'(commit_ready), 128'(4'b0001));
    checkOutput();

    // Contention: all four write every cycle.
    repeat (8) begin
      applyStimulus(4'hF, 4'hF, 4'hF);
      checkOutput();
    end
    applyStimulus(4'h0, 4'h0, 4'h0);
    checkOutput();
    checkOutput();
    checkVal("contention_count", 128'(retired_count), 128'(9));

    // Mixed: ALU writes, LSU and SFU retire without writing.
    applyStimulus(4'b1011, 4'b0001, 4'b1111);
    commit_rd[5:0] = 6'd5;
    checkOutput();
    checkVal("mixed_rd", 128'(wb_rd), 128'(5));
    checkVal("mixed_count", 128'(retired_count), 128'(12));

    // Multi-packet LSU instruction interleaved with FPU writes.
    lsu_beats = 0;
    guard     = 0;
    while (lsu_beats < 3 && guard < 12) begin
      applyStimulus(4'b0110, 4'b0110, {1'b0, 1'b1, (lsu_beats == 2), 1'b0});
      checkOutput();
      if (m_grant == 1) lsu_beats++;
      guard++;
    end
    checkVal("multipacket_done", 128'(lsu_beats), 128'(3));

    // Asynchronous reset between edges while a beat is showing.
    applyStimulus(4'hF, 4'hF, 4'hF);
    checkOutput();
    #2 reset = 1'b0;
    #1;
    m_ptr   = 0;
    m_count = '0;
    m_beat  = 1'b0;
    checkVal("midreset_wb_valid", 128'(wb_valid),      128'(0));
    checkVal("midreset_count",    128'(retired_count), 128'(0));
    checkVal("midreset_ready",    128'(commit_ready),  128'(0));
    @(posedge clk);
    #1 checkVal("midreset_hold", 128'(wb_valid), 128'(0));
    reset = 1'b1;
    #1 checkVal("post_reset_grant", 128'(commit_ready), 128'(4'b0001));
    checkOutput();

    // Counter wrap from all-ones.
    applyStimulus(4'h0, 4'h0, 4'h0);
    force dut.retired_q = {CW{1'b1}};
    #1 release dut.retired_q;
    m_count = {CW{1'b1}};
    checkOutput();
    applyStimulus(4'b0011, 4'b0000, 4'b0011);
    checkOutput();
    checkVal("wrap_count", 128'(retired_count), 128'(1));

    // Random traffic.
    repeat (400) begin
      applyStimulus(4'($urandom), 4'($urandom), 4'($urandom));
      checkOutput();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_commit_arb.md
Name: vx_commit_arb

Overview:
- Transmitter end of the writeback interface for one issue slot.
- Collects per-execute-unit commit streams (ALU, LSU, FPU, SFU) and arbitrates round-robin among commits that write the register file.
- Drives one registered writeback beat per cycle to the scoreboard and operand stages.
- Retires non-writing commits immediately and counts retired instructions.
- Instantiated once per issue slot inside the commit stage.

Parameters:
NUM_EX, 4, number of execute-unit commit inputs (index 0=ALU, 1=LSU, 2=FPU, 3=SFU)
NUM_THREADS, 4, threads per warp (tmask width)
XLEN, 32, register data width per thread
NR_BITS, 6, register index width
WIS_BITS, 2, warp-in-slot index width
UUID_WIDTH, 44, instruction uuid width
CTR_BITS, 64, retired-instruction counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
commit_valid  in  NUM_EX  per-unit commit valid
commit_ready  out  NUM_EX  per-unit commit accept
commit_wb  in  NUM_EX  commit writes rd
commit_eop  in  NUM_EX  last packet of instruction
commit_uuid  in  NUM_EX*UUID_WIDTH  per-unit uuid
commit_wis  in  NUM_EX*WIS_BITS  per-unit warp index
commit_tmask  in  NUM_EX*NUM_THREADS  per-unit thread mask
commit_rd  in  NUM_EX*NR_BITS  per-unit destination register
commit_data  in  NUM_EX*NUM_THREADS*XLEN  per-unit result data
wb_valid  out  1  writeback beat valid (no backpressure)
wb_uuid  out  UUID_WIDTH  writeback uuid
wb_wis  out  WIS_BITS  writeback warp index
wb_tmask  out  NUM_THREADS  writeback thread mask
wb_rd  out  NR_BITS  writeback register
wb_data  out  NUM_THREADS*XLEN  writeback data
wb_eop  out  1  writeback end-of-packet
retired_count  out  CTR_BITS  running count of retired instructions

Behaviour:
- Reset: asynchronous, active-low; all register/counter state clears while reset=0. Output reset values: wb_valid=0, all wb_* fields=0, rr pointer=0, retired_count=0, commit_ready=0.
- Reset mid-operation: any registered beat is dropped; no partial beat after deassertion.
- Non-writing commits (commit_valid[i] && !commit_wb[i]): commit_ready[i]=1 combinationally in the same cycle. Any number accepted per cycle; they never use the writeback port.
- Writing requests: req[i] = commit_valid[i] && commit_wb[i].
- Arbitration: round-robin over req, starting at rr pointer; at most one grant per cycle.
  - commit_ready[i] = grant[i] for writing inputs.
  - Pointer moves to (granted index + 1) mod NUM_EX; unchanged when no grant.
  - Starvation bound: a continuously requesting input is granted within NUM_EX cycles.
- Output stage: registered, latency 1. On a grant, the next cycle shows wb_valid=1 with the granted unit's fields. Without a grant, wb_valid=0 and the fields hold their last values (don't-care).
- Multi-packet instructions: eop=0 beats are arbitrated like any other beat. The arbiter does not lock to a unit; interleaving across units is legal because rd/wis identify the beat.
- Retire count: each cycle, retired_count increments by the number of fires (valid && ready) with eop=1, counting writing and non-writing commits. Width CTR_BITS, wraps modulo 2^CTR_BITS. Registered, so it reflects the previous cycle's fires.
- Simultaneous events: a granted writing commit and up to NUM_EX-1 non-writing commits all fire in one cycle, and all count.
- commit_ready must not depend on wb_* state.

Decomposition:
- Shared package holds the commit and writeback packet structs (uuid, wis, tmask, rd, data, eop), the EX index constants (EX_ALU/EX_LSU/EX_FPU/EX_SFU) and the NUM_EX constant.
- One sub-module: vx_rr_arbiter (parameterised N, req in, one-hot grant out, pointer advance on fire), reusable elsewhere.
- Popcount for retire increment is inline.

Test Plan:
- Reset: hold reset=0 with all commit_valid=1 -> commit_ready=0, wb_valid=0, retired_count=0; release -> first grant to unit 0 (ALU).
- Contention: all 4 units have wb=1, eop=1 for 8 cycles -> wb beats in order ALU,LSU,FPU,SFU,ALU,..., each 1 cycle after grant; retired_count=8 two cycles after the last fire.
- Mixed commits: ALU wb=1, LSU wb=0, SFU wb=0, all eop=1 in one cycle -> all three ready that cycle; one wb beat (ALU, rd=5, data per thread) next cycle; retired_count +3.
- Multi-packet: LSU sends 3 beats eop=0,0,1 interleaved with FPU requests -> beats alternate under round-robin; retired_count +1 for LSU and +1 per FPU eop only.
- Async reset mid-beat: assert reset between edges while wb_valid=1 -> wb_valid drops to 0 immediately; pointer and counter return to 0.
- Wrap: preload counter to 2^CTR_BITS-1 via force, retire 2 -> retired_count=1.
